// File: rtl/uart_mem_initiator.sv
// uart_mem_initiator: host-side UART command initiator for the memory bridge.
// Serializes read/write requests onto serial_out and collects the reply.
// Ports:
//   clk, rst         clock; synchronous active-low reset
//   req_valid/ready  request handshake (ready only in IDLE)
//   req_rw           1 = read, 0 = write
//   req_address      15-bit word address
//   req_data         32-bit write data
//   serial_out       UART TX, 8N1, LSB first, idle high
//   serial_in        UART RX, asynchronous
//   rsp_valid        one-cycle completion / unsolicited-error pulse
//   rsp_data         read word
//   rsp_error        bridge error code (0 = none)
//   rsp_timeout      read reply missing or incomplete
//   busy             state is not IDLE
module uart_mem_initiator #(
  parameter int CLKS_PER_BIT = 868,
  parameter int RESP_TIMEOUT = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [14:0] req_address,
  input  logic [31:0] req_data,
  output logic        serial_out,
  input  logic        serial_in,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_error,
  output logic        rsp_timeout,
  output logic        busy
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int TW = $clog2(RESP_TIMEOUT + 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] C_FULL = CW'(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [TW-1:0] T_MAX  = TW'(RESP_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_WAIT, S_COLLECT, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  state_t state, state_nx;
  logic   accept;

  assign accept = req_valid && (state == S_IDLE);

  // transmitter
  logic          tx_busy;
  logic          tx_done;
  logic          tx_line;
  logic          rw_q;
  logic [CW-1:0] tx_clk;
  logic [3:0]    tx_bit;
  logic [2:0]    tx_byte;
  logic [2:0]    tx_last;
  logic [7:0]    tx_sh;
  logic [47:0]   tx_fr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
      tx_line <= 1'b1;
      rw_q    <= 1'b0;
      tx_clk  <= '0;
      tx_bit  <= '0;
      tx_byte <= '0;
      tx_last <= '0;
      tx_sh   <= '0;
      tx_fr   <= '0;
    end else begin
      tx_done <= 1'b0;
      if (accept) begin
        tx_busy <= 1'b1;
        tx_line <= 1'b0;
        tx_clk  <= '0;
        tx_bit  <= '0;
        tx_byte <= '0;
        tx_last <= req_rw ? 3'd2 : 3'd6;
        tx_sh   <= {7'd0, req_rw};
        tx_fr   <= {1'b0, req_address, req_data};
        rw_q    <= req_rw;
      end else if (tx_busy) begin
        if (tx_clk == C_END) begin
          tx_clk <= '0;
          if (tx_bit == 4'd9) begin
            if (tx_byte == tx_last) begin
              tx_busy <= 1'b0;
              tx_done <= 1'b1;
            end else begin
              // next start bit follows the stop bit directly
              tx_byte <= tx_byte + 3'd1;
              tx_bit  <= '0;
              tx_line <= 1'b0;
              tx_sh   <= tx_fr[47:40];
              tx_fr   <= {tx_fr[39:0], 8'h00};
            end
          end else begin
            tx_bit <= tx_bit + 4'd1;
            if (tx_bit == 4'd8) begin
              tx_line <= 1'b1;
            end else begin
              tx_line <= tx_sh[0];
              tx_sh   <= {1'b0, tx_sh[7:1]};
            end
          end
        end else begin
          tx_clk <= tx_clk + C_ONE;
        end
      end
    end
  end

  // receiver
  rx_state_t     rx_st;
  logic          rx_s1, rx_s2, rx_prev;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          rx_valid;
  logic [7:0]    rx_byte;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_st    <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_valid <= 1'b0;
      rx_byte  <= '0;
    end else begin
      rx_s1    <= serial_in;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_valid <= 1'b0;
      unique case (rx_st)
        RX_IDLE: begin
          if (!rx_s2 && rx_prev) begin
            rx_st  <= RX_START;
            rx_cnt <= C_ONE;
          end
        end
        RX_START: begin
          if (rx_cnt == C_HALF) begin
            // high at mid-bit: glitch, not a start bit
            if (rx_s2) begin
              rx_st <= RX_IDLE;
            end else begin
              rx_st  <= RX_DATA;
              rx_cnt <= C_ONE;
              rx_bit <= '0;
            end
          end else begin
            rx_cnt <= rx_cnt + C_ONE;
          end
        end
        RX_DATA: begin
          if (rx_cnt == C_FULL) begin
            rx_cnt <= C_ONE;
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            if (rx_bit == 3'd7) rx_st <= RX_STOP;
            else rx_bit <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + C_ONE;
          end
        end
        RX_STOP: begin
          if (rx_cnt == C_FULL) begin
            rx_st <= RX_IDLE;
            // framing error drops the byte
            if (rx_s2) begin
              rx_valid <= 1'b1;
              rx_byte  <= rx_sh;
            end
          end else begin
            rx_cnt <= rx_cnt + C_ONE;
          end
        end
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

  // reply timeout, restarted by every received byte
  logic [TW-1:0] tmo;
  logic          tmo_hit;

  assign tmo_hit = (tmo == T_MAX);

  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo <= '0;
    end else if ((state != S_WAIT && state != S_COLLECT) || rx_valid) begin
      tmo <= '0;
    end else if (!tmo_hit) begin
      tmo <= tmo + T_ONE;
    end
  end

  logic rx_code;
  logic [23:0] res_sh;
  logic [2:0]  rx_n;
  logic        res_code;

  assign rx_code  = (rx_byte[7:2] == 6'd0) && (rx_byte[1:0] != 2'd0);
  assign res_code = (res_sh[7:2] == 6'd0) && (res_sh[1:0] != 2'd0);

  // state register
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else state <= state_nx;
  end

  // next state
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (accept) state_nx = S_SEND;
        else if (rx_valid && rx_code) state_nx = S_DONE;
      end
      S_SEND: begin
        if (tx_done) state_nx = rw_q ? S_WAIT : S_DONE;
      end
      S_WAIT: begin
        if (rx_valid) state_nx = S_COLLECT;
        else if (tmo_hit) state_nx = S_DONE;
      end
      S_COLLECT: begin
        if (rx_valid && rx_n == 3'd3) state_nx = S_DONE;
        else if (!rx_valid && tmo_hit) state_nx = S_DONE;
      end
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    req_ready = (state == S_IDLE);
    busy      = (state != S_IDLE);
    rsp_valid = (state == S_DONE);
  end

  // reply assembly and result registers, loaded on entry to DONE
  logic [31:0] rsp_data_q;
  logic [1:0]  rsp_error_q;
  logic        rsp_timeout_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      res_sh        <= '0;
      rx_n          <= '0;
      rsp_data_q    <= '0;
      rsp_error_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      if (state == S_WAIT && rx_valid) begin
        res_sh <= {16'd0, rx_byte};
        rx_n   <= 3'd1;
      end else if (state == S_COLLECT && rx_valid) begin
        res_sh <= {res_sh[15:0], rx_byte};
        rx_n   <= rx_n + 3'd1;
      end
      if (state_nx == S_DONE) begin
        rsp_data_q    <= '0;
        rsp_error_q   <= '0;
        rsp_timeout_q <= 1'b0;
        if (state == S_IDLE) begin
          rsp_error_q <= rx_byte[1:0];
        end else if (state == S_COLLECT && rx_valid) begin
          rsp_data_q <= {res_sh, rx_byte};
        end else if (state == S_COLLECT && rx_n == 3'd1 && res_code) begin
          rsp_error_q <= res_sh[1:0];
        end else if (state == S_WAIT || state == S_COLLECT) begin
          rsp_timeout_q <= 1'b1;
        end
      end
    end
  end

  assign serial_out  = tx_line;
  assign rsp_data    = rsp_data_q;
  assign rsp_error   = rsp_error_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_uart_mem_initiator.sv
// tb_uart_mem_initiator: directed self-checking bench for uart_mem_initiator.
// Decodes the TX frame, plays the bridge's replies and checks responses.
module tb_uart_mem_initiator;

  localparam int CPB  = 4;
  localparam int TMO  = 200;
  localparam int BYTE = 10 * CPB;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [14:0] req_address;
  logic [31:0] req_data;
  logic        serial_out;
  logic        serial_in;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_error;
  logic        rsp_timeout;
  logic        busy;

  uart_mem_initiator #(
    .CLKS_PER_BIT(CPB),
    .RESP_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_rw(req_rw),
    .req_address(req_address),
    .req_data(req_data),
    .serial_out(serial_out),
    .serial_in(serial_in),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .rsp_error(rsp_error),
    .rsp_timeout(rsp_timeout),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int acc;

  always @(posedge clk) cyc <= cyc + 1;

  int          rsp_cnt = 0;
  int          m_cyc = 0;
  logic [31:0] m_data = '0;
  logic [1:0]  m_err = '0;
  logic        m_to = 1'b0;

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      rsp_cnt <= rsp_cnt + 1;
      m_cyc   <= cyc;
      m_data  <= rsp_data;
      m_err   <= rsp_error;
      m_to    <= rsp_timeout;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic rw, input logic [14:0] a,
                           input logic [31:0] d);
    req_rw      = rw;
    req_address = a;
    req_data    = d;
    req_valid   = 1'b1;
    acc         = cyc;
    check("req_ready", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid   = 1'b0;
    req_rw      = ~rw;
    req_address = '1;
    req_data    = '1;
    check("tx_start", {31'd0, serial_out}, 32'd0);
  endtask

  task automatic tx_get(output logic [7:0] b, output int st,
                        output logic stp);
    int n;
    n = 0;
    while (serial_out !== 1'b0 && n < 2000) begin
      tick();
      n++;
    end
    check("tx_start_seen", {31'd0, n < 2000}, 32'd1);
    st = cyc;
    repeat (CPB / 2) tick();
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) tick();
      b[i] = serial_out;
    end
    repeat (CPB) tick();
    stp = serial_out;
  endtask

  task automatic chk_frame(input string tag, input int n,
                           input logic [55:0] fr);
    logic [7:0] b;
    logic       stp;
    int         st;
    int         prev;
    prev = 0;
    for (int i = 0; i < n; i++) begin
      tx_get(b, st, stp);
      check($sformatf("%s_byte%0d", tag, i), {24'd0, b},
            {24'd0, fr[55-8*i -: 8]});
      check($sformatf("%s_stop%0d", tag, i), {31'd0, stp}, 32'd1);
      if (i > 0) check($sformatf("%s_gap%0d", tag, i), st - prev, BYTE);
      prev = st;
    end
  endtask

  task automatic rx_send(input logic [7:0] b);
    serial_in = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (CPB) tick();
    end
    serial_in = 1'b1;
    repeat (CPB) tick();
  endtask

  task automatic wait_rsp(input int n0, input int bound, output bit ok);
    int k;
    k = 0;
    while (rsp_cnt == n0 && k < bound) begin
      tick();
      k++;
    end
    ok = (rsp_cnt != n0);
  endtask

  int n0;
  int e;
  int k;
  bit ok;

  initial begin
    rst         = 1'b0;
    req_valid   = 1'b0;
    req_rw      = 1'b0;
    req_address = '0;
    req_data    = '0;
    serial_in   = 1'b1;
    repeat (3) tick();

    check("rst_serial_out", {31'd0, serial_out}, 32'd1);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_error", {30'd0, rsp_error}, 32'd0);
    check("rst_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
    rst = 1'b1;
    tick();

    // write 0x1234 <- 0xDEADBEEF
    n0 = rsp_cnt;
    start_req(1'b0, 15'h1234, 32'hDEADBEEF);
    check("wr_busy", {31'd0, busy}, 32'd1);
    chk_frame("wr", 7, 56'h00_12_34_DE_AD_BE_EF);
    wait_rsp(n0, 100, ok);
    check("wr_rsp_seen", {31'd0, ok}, 32'd1);
    check("wr_latency", m_cyc - acc, 32'd282);
    check("wr_err", {30'd0, m_err}, 32'd0);
    check("wr_to", {31'd0, m_to}, 32'd0);

    // read 0x7FFF -> CAFEBABE
    n0 = rsp_cnt;
    start_req(1'b1, 15'h7FFF, 32'h0);
    chk_frame("rd", 3, 56'h01_7F_FF_00_00_00_00);
    repeat (4) tick();
    rx_send(8'hCA);
    rx_send(8'hFE);
    rx_send(8'hBA);
    rx_send(8'hBE);
    wait_rsp(n0, 100, ok);
    check("rd_rsp_seen", {31'd0, ok}, 32'd1);
    check("rd_data", m_data, 32'hCAFEBABE);
    check("rd_err", {30'd0, m_err}, 32'd0);
    check("rd_to", {31'd0, m_to}, 32'd0);

    // read answered with error byte 02
    n0 = rsp_cnt;
    start_req(1'b1, 15'h0005, 32'h0);
    chk_frame("rde", 3, 56'h01_00_05_00_00_00_00);
    repeat (4) tick();
    rx_send(8'h02);
    e = cyc;
    check("rde_no_early", rsp_cnt, n0);
    wait_rsp(n0, 400, ok);
    check("rde_rsp_seen", {31'd0, ok}, 32'd1);
    check("rde_err", {30'd0, m_err}, 32'd2);
    check("rde_data", m_data, 32'd0);
    check("rde_to", {31'd0, m_to}, 32'd0);
    check("rde_wait_window",
          {31'd0, (m_cyc - e) >= TMO - 20 && (m_cyc - e) <= TMO + 20},
          32'd1);

    // read with no reply
    n0 = rsp_cnt;
    start_req(1'b1, 15'h0100, 32'h0);
    chk_frame("rdt", 3, 56'h01_01_00_00_00_00_00);
    wait_rsp(n0, 400, ok);
    check("rdt_rsp_seen", {31'd0, ok}, 32'd1);
    check("rdt_to", {31'd0, m_to}, 32'd1);
    check("rdt_err", {30'd0, m_err}, 32'd0);

    // unsolicited error byte while idle
    n0 = rsp_cnt;
    rx_send(8'h03);
    repeat (10) tick();
    check("uns3_pulses", rsp_cnt, n0 + 1);
    check("uns3_err", {30'd0, m_err}, 32'd3);
    check("uns3_data", m_data, 32'd0);
    check("uns3_to", {31'd0, m_to}, 32'd0);
    check("uns3_idle", {31'd0, busy}, 32'd0);

    // ordinary byte while idle is dropped
    n0 = rsp_cnt;
    rx_send(8'h55);
    repeat (10) tick();
    check("uns55_pulses", rsp_cnt, n0);
    check("uns55_err_hold", {30'd0, rsp_error}, 32'd3);

    // start glitch shorter than half a bit
    serial_in = 1'b0;
    tick();
    serial_in = 1'b1;
    repeat (60) tick();
    check("glitch_pulses", rsp_cnt, n0);
    rx_send(8'h01);
    repeat (10) tick();
    check("post_glitch_pulses", rsp_cnt, n0 + 1);
    check("post_glitch_err", {30'd0, m_err}, 32'd1);

    // reset during byte 4 of a write
    n0 = rsp_cnt;
    start_req(1'b0, 15'h0101, 32'h11223344);
    chk_frame("wrr", 4, 56'h00_01_01_11_22_33_44);
    repeat (2) tick();
    check("rst_mid_low", {31'd0, serial_out}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("rst_mid_line", {31'd0, serial_out}, 32'd1);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    repeat (3) tick();
    rst = 1'b1;
    repeat (300) tick();
    check("rst_mid_no_rsp", rsp_cnt, n0);
    check("rst_mid_line_idle", {31'd0, serial_out}, 32'd1);

    n0 = rsp_cnt;
    start_req(1'b1, 15'h0ABC, 32'h0);
    chk_frame("rdp", 3, 56'h01_0A_BC_00_00_00_00);
    repeat (4) tick();
    rx_send(8'h12);
    rx_send(8'h34);
    rx_send(8'h56);
    rx_send(8'h78);
    wait_rsp(n0, 100, ok);
    check("rdp_rsp_seen", {31'd0, ok}, 32'd1);
    check("rdp_data", m_data, 32'h12345678);
    check("rdp_err", {30'd0, m_err}, 32'd0);

    // request held across two transactions
    n0 = rsp_cnt;
    req_rw      = 1'b0;
    req_address = 15'h0042;
    req_data    = 32'hA5A55A5A;
    req_valid   = 1'b1;
    k = 0;
    tick();
    while (rsp_valid !== 1'b1 && k < 1000) begin
      tick();
      k++;
    end
    check("held_first_rsp", {31'd0, rsp_valid}, 32'd1);
    check("held_ready_low", {31'd0, req_ready}, 32'd0);
    tick();
    check("held_ready_rise", {31'd0, req_ready}, 32'd1);
    tick();
    check("held_second_start", {31'd0, serial_out}, 32'd0);
    req_valid   = 1'b0;
    req_address = '0;
    req_data    = '0;
    chk_frame("held", 7, 56'h00_00_42_A5_A5_5A_5A);
    wait_rsp(n0 + 1, 100, ok);
    check("held_second_rsp", {31'd0, ok}, 32'd1);
    check("held_second_err", {30'd0, m_err}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
